// File: rtl/ula_ctrl.sv
// ula_ctrl: request/response sequencer for the 3-bit-op ALU.
//   Decodes MIPS opcode/funct into an ALU op. It drives the ALU from registers,
//   then captures the ALU result and zero flag and returns them on a response
//   channel. Only one transaction is in flight at a time.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_opcode, req_funct        MIPS primary opcode / funct (funct used when opcode==0)
//   req_a, req_b                 operands (immediates pre-extended by requester)
//   alu_op, alu_a, alu_b         registered ALU drive
//   alu_resultado, alu_zero      combinational ALU return
//   resp_valid/resp_ready        response handshake
//   resp_resultado, resp_zero    captured ALU result / zero flag
//   resp_illegal                 request failed to decode
// Optional feature: define ULA_CTRL_STATS_EN to add the stat_ops / stat_illegal counters.
module ula_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_opcode,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_resultado,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_resultado,
  output logic             resp_zero,
  output logic             resp_illegal
`ifdef ULA_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_illegal
`endif
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [OP_W-1:0] dec_op_c;
  logic            dec_legal_c;

  // Opcode/funct to ALU op decode
  always_comb begin
    dec_op_c    = '0;
    dec_legal_c = 1'b1;
    if (req_opcode == 6'h00) begin
      case (req_funct)
        6'h20:   dec_op_c = OP_W'(0);
        6'h22:   dec_op_c = OP_W'(1);
        6'h24:   dec_op_c = OP_W'(2);
        6'h25:   dec_op_c = OP_W'(3);
        6'h26:   dec_op_c = OP_W'(4);
        6'h18:   dec_op_c = OP_W'(5);
        6'h04:   dec_op_c = OP_W'(6);
        6'h06:   dec_op_c = OP_W'(7);
        default: dec_legal_c = 1'b0;
      endcase
    end else begin
      case (req_opcode)
        6'h08:   dec_op_c = OP_W'(0);
        6'h04:   dec_op_c = OP_W'(1);
        6'h0C:   dec_op_c = OP_W'(2);
        6'h0D:   dec_op_c = OP_W'(3);
        6'h0E:   dec_op_c = OP_W'(4);
        default: dec_legal_c = 1'b0;
      endcase
    end
  end

  // Sequencer: state plus all registered outputs.
  // req_ready is a flop that mirrors (state_q == S_IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      req_ready      <= 1'b1;
      alu_op         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      resp_valid     <= 1'b0;
      resp_resultado <= '0;
      resp_zero      <= 1'b0;
      resp_illegal   <= 1'b0;
`ifdef ULA_CTRL_STATS_EN
      stat_ops       <= '0;
      stat_illegal   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (dec_legal_c) begin
              alu_op  <= dec_op_c;
              alu_a   <= req_a;
              alu_b   <= req_b;
              state_q <= S_EXEC;
            end else begin
              // Illegal requests skip the ALU; its registers keep their last values.
              resp_illegal   <= 1'b1;
              resp_resultado <= '0;
              resp_zero      <= 1'b0;
              resp_valid     <= 1'b1;
              state_q        <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          resp_resultado <= alu_resultado;
          resp_zero      <= alu_zero;
          resp_illegal   <= 1'b0;
          resp_valid     <= 1'b1;
          state_q        <= S_RESP;
        end
        S_RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= S_IDLE;
`ifdef ULA_CTRL_STATS_EN
            if (resp_illegal) stat_illegal <= stat_illegal + 16'd1;
            else              stat_ops     <= stat_ops + 32'd1;
`endif
          end
        end
        default: begin
          state_q    <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
